// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and load/store requesters.
// Data side has fixed priority; fetch is forced through after STARVE_LIMIT contested data grants.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             grant_i, grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Reset masks every grant so nothing reaches the SRAM while the core restarts.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (inst_req && data_req) begin
        if (starve_cnt_q == LIMIT) grant_i = 1'b1;
        else                       grant_d = 1'b1;
      end else if (inst_req) begin
        grant_i = 1'b1;
      end else if (data_req) begin
        grant_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = IDLE;
    starve_cnt_d = starve_cnt_q;
    if (grant_i) begin
      state_d      = RESP_I;
      starve_cnt_d = '0;
    end else if (grant_d) begin
      state_d = RESP_D;
      if (inst_req && starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    inst_addr_ok = grant_i;
    data_addr_ok = grant_d;
    sram_en      = grant_i | grant_d;
    sram_wen     = grant_d ? data_wen : '0;
    sram_addr    = grant_i ? inst_addr : data_addr;
    sram_wdata   = grant_i ? '0 : data_wdata;
    // A response whose cycle overlaps reset is dropped.
    inst_data_ok = (state_q == RESP_I) && !reset;
    data_data_ok = (state_q == RESP_D) && !reset;
    inst_rdata   = sram_rdata;
    data_rdata   = sram_rdata;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and checks them against data_ok/rdata.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata;

  typedef struct {
    bit          side_d;
    bit          chk_data;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_bad = 0;
  logic [31:0] mem [16];

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: word index addr[5:2]; reset reloads mem[i] = 0x10000000 + i.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      sram_rdata <= '0;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr[5:2]];
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit side_d, input bit chk_data, input logic [31:0] rdata);
    exp_t e;
    e.side_d   = side_d;
    e.chk_data = chk_data;
    e.rdata    = rdata;
    e.due      = cyc + 1;
    sb.push_back(e);
  endtask

  // Monitor: compares each data_ok cycle with the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check_output("resp_side", {62'b0, inst_data_ok, data_data_ok},
                   e.side_d ? 64'd1 : 64'd2);
      if (e.chk_data)
        check_output("resp_rdata", e.side_d ? data_rdata : inst_rdata, e.rdata);
    end else if (inst_data_ok || data_data_ok) begin
      check_output("unexpected_data_ok", {62'b0, inst_data_ok, data_data_ok}, 64'd0);
    end
  end

  task automatic apply_stimulus(input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic [3:0] dwen,
                                input logic [31:0] daddr, input logic [31:0] dwdata);
    inst_req   = ireq;
    inst_addr  = iaddr;
    data_req   = dreq;
    data_wen   = dwen;
    data_addr  = daddr;
    data_wdata = dwdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Both sides held requesting (inst 0x8, data load 0xC) for n cycles; bit k of mask = fetch wins.
  task automatic contest(input int n, input logic [15:0] mask, input bit push_last, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_output($sformatf("%s_iok%0d", tag, k), {63'b0, inst_addr_ok}, {63'b0, mask[k]});
      check_output($sformatf("%s_dok%0d", tag, k), {63'b0, data_addr_ok}, {63'b0, !mask[k]});
      check_output($sformatf("%s_addr%0d", tag, k), {32'b0, sram_addr},
                   mask[k] ? 64'h8 : 64'hC);
      if (push_last || k != n - 1)
        push_exp(!mask[k], 1'b1, mask[k] ? 32'h1000_0002 : 32'h1000_0003);
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(1'b1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check_output("rst_sram_en", {63'b0, sram_en}, 64'd0);
      check_output("rst_grants", {62'b0, inst_addr_ok, data_addr_ok}, 64'd0);
      check_output("rst_data_ok", {62'b0, inst_data_ok, data_data_ok}, 64'd0);
    end
    next_cycle();
    reset = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    next_cycle();

    // Fetch 0xBFC00000 -> word 0 = 0x10000000
    apply_stimulus(1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check_output("t1_iok", {62'b0, inst_addr_ok, data_addr_ok}, 64'd2);
    check_output("t1_en", {63'b0, sram_en}, 64'd1);
    check_output("t1_addr", {32'b0, sram_addr}, 64'hBFC0_0000);
    check_output("t1_wen", {60'b0, sram_wen}, 64'd0);
    check_output("t1_wdata", {32'b0, sram_wdata}, 64'd0);
    push_exp(1'b0, 1'b1, 32'h1000_0000);
    next_cycle();

    // Store 0xDEADBEEF to 0x1000 (word 0), then load it back in the store's data_ok cycle.
    apply_stimulus(1'b0, 32'h0, 1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
    @(negedge clk);
    check_output("t2_dok", {62'b0, inst_addr_ok, data_addr_ok}, 64'd1);
    check_output("t2_wen", {60'b0, sram_wen}, 64'hF);
    check_output("t2_wdata", {32'b0, sram_wdata}, 64'hDEAD_BEEF);
    check_output("t2_addr", {32'b0, sram_addr}, 64'h1000);
    push_exp(1'b1, 1'b0, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_1000, 32'h0);
    @(negedge clk);
    check_output("t2_load_wen", {60'b0, sram_wen}, 64'd0);
    push_exp(1'b1, 1'b1, 32'hDEAD_BEEF);
    next_cycle();

    // Contention for 8 cycles: D,D,D,I,D,D,D,I
    apply_stimulus(1'b1, 32'h8, 1'b1, 4'h0, 32'hC, 32'h0);
    contest(8, 16'h0088, 1'b1, "t3");

    // Back-to-back fetches; word 0 now holds the stored value.
    apply_stimulus(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_rd;
      inst_addr = 32'(4 * k);
      exp_rd = (k == 0) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(k);
      @(negedge clk);
      check_output($sformatf("t4_iok%0d", k), {63'b0, inst_addr_ok}, 64'd1);
      push_exp(1'b0, 1'b1, exp_rd);
      next_cycle();
    end

    // Contest twice (starve count 2), reset during the second grant's response cycle.
    apply_stimulus(1'b1, 32'h8, 1'b1, 4'h0, 32'hC, 32'h0);
    contest(2, 16'h0000, 1'b0, "t5pre");
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_output("t5_data_ok", {62'b0, inst_data_ok, data_data_ok}, 64'd0);
      check_output("t5_sram_en", {63'b0, sram_en}, 64'd0);
      check_output("t5_grants", {62'b0, inst_addr_ok, data_addr_ok}, 64'd0);
      next_cycle();
    end
    reset = 1'b0;
    // Starve count cleared: D,D,D,I (memory reloaded by reset)
    contest(4, 16'h0008, 1'b1, "t5post");

    // Drain the last response, then four idle cycles.
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output($sformatf("t6_en_wen%0d", k), {59'b0, sram_en, sram_wen}, 64'd0);
      check_output($sformatf("t6_ok%0d", k),
                   {60'b0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 64'd0);
      next_cycle();
    end

    check_output("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
